// File: rtl/gost34_13_2015_pkg.sv
// Shared types and constants for the GOST R 34.13-2015 CTR front-end.
package gost34_13_2015_pkg;

  localparam int unsigned GOST_BLK_W = 128;
  localparam int unsigned GOST_IV_W  = 64;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    LAUNCH,
    SETTLE,
    WAIT,
    OUT
  } ctr_state_t;

endpackage

// File: rtl/gost34_13_2015_ctr_gen.sv
// Counter-block generator: holds the IV and the low counter half, ctr = {iv_reg, lo}.
module gost34_13_2015_ctr_gen
  import gost34_13_2015_pkg::*;
#(
  parameter int unsigned IV_W  = GOST_IV_W,
  parameter int unsigned BLK_W = GOST_BLK_W
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             load,
  input  logic [IV_W-1:0]  iv,
  input  logic             inc,
  output logic [BLK_W-1:0] ctr,
  output logic             wrap
);

  localparam int unsigned LO_W = BLK_W - IV_W;

  logic [IV_W-1:0] iv_reg;
  logic [LO_W-1:0] lo;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      iv_reg <= '0;
      lo     <= '0;
    end else if (load) begin
      iv_reg <= iv;
      lo     <= '0;
    end else if (inc) begin
      lo <= lo + LO_W'(1);
    end
  end

  assign ctr  = {iv_reg, lo};
  // High while the pending increment takes lo from all-ones back to zero.
  assign wrap = inc && (lo == '1);

endmodule

// File: rtl/gost34_13_2015_ctr_stream.sv
// GOST R 34.13-2015 CTR stream front-end for the 32-round ECB core.
// Optional counter-wrap guard: define GOST_CTR_WRAP_GUARD_EN.
module gost34_13_2015_ctr_stream
  import gost34_13_2015_pkg::*;
#(
  parameter int unsigned IV_W  = GOST_IV_W,
  parameter int unsigned BLK_W = GOST_BLK_W
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             iv_load,
  input  logic [IV_W-1:0]  iv,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [BLK_W-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [BLK_W-1:0] m_data,
  output logic             m_last,
  output logic             core_load,
  output logic [BLK_W-1:0] core_in,
  input  logic             core_busy,
  input  logic [BLK_W-1:0] core_out
`ifdef GOST_CTR_WRAP_GUARD_EN
  ,
  output logic             ctr_exhausted
`endif
);

  ctr_state_t       state, state_nxt;
  logic [BLK_W-1:0] ctr;
  logic [BLK_W-1:0] data_reg;
  logic             last_reg;
  logic             lo_wrap;
  logic             iv_take;
  logic             accept;
  logic             capture;

  // IV reloads are honoured only while no block is in flight.
  assign iv_take   = iv_load && (state == IDLE || state == READY);
  assign s_ready   = (state == READY) && !iv_load;
  assign accept    = s_ready && s_valid;
  assign capture   = (state == WAIT) && !core_busy;
  assign core_load = (state == LAUNCH);
  assign m_valid   = (state == OUT);

  gost34_13_2015_ctr_gen #(
    .IV_W  (IV_W),
    .BLK_W (BLK_W)
  ) u_ctr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (iv_take),
    .iv      (iv),
    .inc     (core_load),
    .ctr     (ctr),
    .wrap    (lo_wrap)
  );

`ifdef GOST_CTR_WRAP_GUARD_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ctr_exhausted <= 1'b0;
    end else if (iv_take) begin
      ctr_exhausted <= 1'b0;
    end else if (lo_wrap) begin
      ctr_exhausted <= 1'b1;
    end
  end
`else
  logic unused_lo_wrap;
  assign unused_lo_wrap = lo_wrap;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iv_load) state_nxt = READY;
      READY:   if (accept) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = SETTLE;
      SETTLE:  state_nxt = WAIT;
      WAIT:    if (!core_busy) state_nxt = OUT;
      OUT: begin
        if (m_ready) begin
`ifdef GOST_CTR_WRAP_GUARD_EN
          state_nxt = ctr_exhausted ? IDLE : READY;
`else
          state_nxt = READY;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= IDLE;
      data_reg <= '0;
      last_reg <= 1'b0;
      core_in  <= '0;
      m_data   <= '0;
      m_last   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_reg <= s_data;
        last_reg <= s_last;
        core_in  <= ctr;
      end
      if (capture) begin
        m_data <= data_reg ^ core_out;
        m_last <= last_reg;
      end
    end
  end

endmodule

// File: tb/tb_gost34_13_2015_ctr_stream.sv
// Self-checking bench for gost34_13_2015_ctr_stream with a 33-cycle stub ECB core.
module tb_gost34_13_2015_ctr_stream;

  localparam logic [127:0] PAD = {16{8'hA5}};

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         iv_load = 1'b0;
  logic [63:0]  iv = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] s_data = '0;
  logic         s_last = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [127:0] m_data;
  logic         m_last;
  logic         core_load;
  logic [127:0] core_in;
  logic         core_busy;
  logic [127:0] core_out;
`ifdef GOST_CTR_WRAP_GUARD_EN
  logic         ctr_exhausted;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  gost34_13_2015_ctr_stream #(
    .IV_W  (64),
    .BLK_W (128)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .iv_load   (iv_load),
    .iv        (iv),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .core_load (core_load),
    .core_in   (core_in),
    .core_busy (core_busy),
    .core_out  (core_out)
`ifdef GOST_CTR_WRAP_GUARD_EN
    ,
    .ctr_exhausted (ctr_exhausted)
`endif
  );

  // Stub core: out = in ^ A5..A5, busy for 33 cycles after load_data; never reset.
  logic         stub_busy = 1'b0;
  logic [5:0]   stub_cnt = '0;
  logic [127:0] stub_out = '0;
  always @(posedge aclk) begin
    if (core_load) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 6'd33;
      stub_out  <= core_in ^ PAD;
    end else if (stub_busy) begin
      if (stub_cnt == 6'd1) stub_busy <= 1'b0;
      else stub_cnt <= stub_cnt - 6'd1;
    end
  end
  assign core_busy = stub_busy;
  assign core_out  = stub_out;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic load_iv(input logic [63:0] v);
    iv = v;
    iv_load = 1'b1;
    #1;
    check("iv_load_ready_low", 128'(s_ready), 128'd0);
    step();
    iv_load = 1'b0;
    iv = {$urandom, $urandom};
  endtask

  // One full block transaction; the bench holds m_ready low for `stall` cycles in OUT.
  task automatic do_block(input logic [127:0] data, input logic last, input logic [127:0] exp_ci,
                          input logic [127:0] exp_md, input int unsigned stall,
                          input logic exp_ready_after);
    int lat;
    int w;
    logic ready_seen;
    logic extra_load;
    s_data = data;
    s_last = last;
    s_valid = 1'b1;
    m_ready = (stall == 0);
    #1;
    w = 0;
    while (!s_ready && w < 50) begin
      step();
      #1;
      w++;
    end
    check("accept_ready", 128'(s_ready), 128'd1);
    step();
    s_valid = 1'b0;
    s_data = {$urandom, $urandom, $urandom, $urandom};
    s_last = ~last;
    check("core_load_pulse", 128'(core_load), 128'd1);
    check("core_in", core_in, exp_ci);
    lat = 1;
    ready_seen = 1'b0;
    extra_load = 1'b0;
    while (!m_valid && lat < 200) begin
      step();
      lat++;
      ready_seen |= s_ready;
      extra_load |= core_load;
    end
    check("m_valid_latency", 128'(lat), 128'd36);
    check("s_ready_inflight", 128'(ready_seen), 128'd0);
    check("core_load_inflight", 128'(extra_load), 128'd0);
    check("m_data", m_data, exp_md);
    check("m_last", 128'(m_last), 128'(last));
    for (int unsigned i = 0; i < stall; i++) begin
      step();
      check("stall_m_valid", 128'(m_valid), 128'd1);
      check("stall_m_data", m_data, exp_md);
      check("stall_s_ready", 128'(s_ready), 128'd0);
      check("stall_core_load", 128'(core_load), 128'd0);
    end
    m_ready = 1'b1;
    step();
    check("m_valid_after_hs", 128'(m_valid), 128'd0);
    check("s_ready_after_hs", 128'(s_ready), 128'(exp_ready_after));
  endtask

  typedef struct {
    logic         ld;
    logic [63:0]  iv;
    logic [127:0] data;
    logic         last;
    int unsigned  stall;
    logic [127:0] ci;
    logic [127:0] md;
  } vec_t;

  vec_t         tbl[4];
  logic [63:0]  ref_iv;
  logic [63:0]  ref_lo;
  logic [127:0] rdata;
  logic         rlast;
  logic [127:0] rci;
  logic         seen_valid;
  logic         seen_load;
  logic         seen_ready;

  initial begin
    tbl[0] = '{1'b1, 64'h0123456789ABCDEF, 128'h0, 1'b1, 0,
               128'h0123456789ABCDEF_0000000000000000, 128'hA486E0C22C0E684A_A5A5A5A5A5A5A5A5};
    tbl[1] = '{1'b0, 64'h0, {128{1'b1}}, 1'b0, 0,
               128'h0123456789ABCDEF_0000000000000001, 128'h5B791F3DD3F197B5_5A5A5A5A5A5A5A5B};
    tbl[2] = '{1'b0, 64'h0, 128'h00112233445566778899AABBCCDDEEFF, 1'b1, 0,
               128'h0123456789ABCDEF_0000000000000002, 128'hA497C2F1685B0E3D_2D3C0F1E69784B58};
    tbl[3] = '{1'b1, 64'hFEDCBA9876543210, 128'h1, 1'b0, 10,
               128'hFEDCBA9876543210_0000000000000000, 128'h5B791F3DD3F197B5_A5A5A5A5A5A5A5A4};

    // Reset state and no acceptance before an IV is loaded.
    step();
    step();
    check("rst_s_ready", 128'(s_ready), 128'd0);
    check("rst_m_valid", 128'(m_valid), 128'd0);
    check("rst_m_last", 128'(m_last), 128'd0);
    check("rst_core_load", 128'(core_load), 128'd0);
    check("rst_m_data", m_data, 128'd0);
    check("rst_core_in", core_in, 128'd0);
    aresetn = 1'b1;
    s_valid = 1'b1;
    s_data = 128'hDEAD;
    step();
    check("idle_s_ready", 128'(s_ready), 128'd0);
    step();
    check("idle_core_load", 128'(core_load), 128'd0);
    s_valid = 1'b0;
    step();

    for (int unsigned i = 0; i < 4; i++) begin
      if (tbl[i].ld) load_iv(tbl[i].iv);
      do_block(tbl[i].data, tbl[i].last, tbl[i].ci, tbl[i].md, tbl[i].stall, 1'b1);
    end

    // iv_load wins over s_valid in READY; the counter restarts at 0.
    ref_iv = 64'h0123456789ABCDEF;
    s_valid = 1'b1;
    s_data = 128'h55;
    iv = ref_iv;
    iv_load = 1'b1;
    #1;
    check("ivld_blocks_accept", 128'(s_ready), 128'd0);
    step();
    iv_load = 1'b0;
    s_valid = 1'b0;
    check("ivld_no_core_load", 128'(core_load), 128'd0);
    rdata = 128'h0F0F_0000_1234_5678_9ABC_DEF0_0000_FFFF;
    rci = {ref_iv, 64'd0};
    do_block(rdata, 1'b1, rci, rdata ^ rci ^ PAD, 0, 1'b1);

    // Reset while waiting on the core: block discarded, late busy fall ignored.
    s_valid = 1'b1;
    s_data = 128'hCAFE;
    #1;
    step();
    s_valid = 1'b0;
    repeat (10) step();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    check("wrst_m_valid", 128'(m_valid), 128'd0);
    check("wrst_s_ready", 128'(s_ready), 128'd0);
    check("wrst_core_in", core_in, 128'd0);
    check("wrst_m_data", m_data, 128'd0);
    check("wrst_m_last", 128'(m_last), 128'd0);
    seen_valid = 1'b0;
    seen_load = 1'b0;
    seen_ready = 1'b0;
    s_valid = 1'b1;
    repeat (40) begin
      step();
      seen_valid |= m_valid;
      seen_load |= core_load;
      seen_ready |= s_ready;
    end
    s_valid = 1'b0;
    check("wrst_no_m_valid", 128'(seen_valid), 128'd0);
    check("wrst_no_core_load", 128'(seen_load), 128'd0);
    check("wrst_idle_no_ready", 128'(seen_ready), 128'd0);

    // Randomized blocks against the {iv, counter} reference model.
    ref_iv = {$urandom, $urandom};
    ref_lo = '0;
    load_iv(ref_iv);
    for (int unsigned n = 0; n < 16; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ref_iv = {$urandom, $urandom};
        ref_lo = '0;
        load_iv(ref_iv);
      end
      rdata = {$urandom, $urandom, $urandom, $urandom};
      rlast = 1'($urandom_range(0, 1));
      rci = {ref_iv, ref_lo};
      do_block(rdata, rlast, rci, rdata ^ rci ^ PAD, $urandom_range(0, 3), 1'b1);
      ref_lo = ref_lo + 64'd1;
    end

`ifdef GOST_CTR_WRAP_GUARD_EN
    check("guard_flag_clear", 128'(ctr_exhausted), 128'd0);
    force dut.u_ctr.lo = '1;
    step();
    release dut.u_ctr.lo;
    rdata = {$urandom, $urandom, $urandom, $urandom};
    rci = {ref_iv, 64'hFFFF_FFFF_FFFF_FFFF};
    do_block(rdata, 1'b1, rci, rdata ^ rci ^ PAD, 0, 1'b0);
    check("guard_flag_set", 128'(ctr_exhausted), 128'd1);
    step();
    check("guard_idle_no_ready", 128'(s_ready), 128'd0);
    load_iv(64'h1111_2222_3333_4444);
    check("guard_flag_cleared", 128'(ctr_exhausted), 128'd0);
    #1;
    check("guard_ready_again", 128'(s_ready), 128'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gost34_13_2015_ctr_stream.md
# gost34_13_2015_ctr_stream

Counter-mode (GOST R 34.13-2015 CTR) front-end placed directly upstream of the 32-round ECB encrypt core. It accepts plaintext/ciphertext blocks on a valid/ready stream and builds counter blocks from a loaded IV. For each block it launches the core through its `load_data`/`busy_ecb` handshake, then XORs the core result with the buffered data block and presents the result on an output stream. One block is in flight at a time; key and sbox connect to the core directly and are not handled here.

## Interface
- `IV_W`, default 64: IV width. The IV forms the upper half of the counter block.
- `BLK_W`, default 128: block width. It must equal the core's `in`/`out_ecb` width.
- `aclk` input, 1 bit: clock.
- `aresetn` input, 1 bit: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `iv_load` input, 1 bit: load a new IV and clear the counter.
- `iv` input, `IV_W` bits: IV value, sampled when `iv_load` is high.
- `s_valid` / `s_ready`: input / output, 1 bit each. Input-block handshake.
- `s_data` input, `BLK_W` bits: input data block.
- `s_last` input, 1 bit: marks the final block of a message. It is passed through unchanged.
- `m_valid` / `m_ready`: output / input, 1 bit each. Output-block handshake.
- `m_data` output, `BLK_W` bits: equals `s_data ^ E(ctr)`.
- `m_last` output, 1 bit: the registered copy of `s_last`.
- `core_load` output, 1 bit: one-cycle pulse that drives the core's `load_data`.
- `core_in` output, `BLK_W` bits: counter block sent to the core.
- `core_busy` input, 1 bit: from the core's `busy_ecb`.
- `core_out` input, `BLK_W` bits: from the core's `out_ecb`.
- `ctr_exhausted` output, 1 bit: present only with `GOST_CTR_WRAP_GUARD_EN`.

## Operation
- Counter block: `ctr = {iv_reg, lo}`, where `lo` is a `BLK_W-IV_W`-bit counter.
  - `iv_load` clears `lo` to 0.
  - `lo` increments by 1 (mod 2^(`BLK_W-IV_W`)) once per accepted input block, when the block is launched.
- FSM states:
  - IDLE: no IV loaded.
  - READY: waiting for an input block.
  - LAUNCH: pulses `core_load`.
  - SETTLE: ignores `core_busy`.
  - WAIT: polls `core_busy`.
  - OUT: presents the result.
- IDLE → READY on `iv_load`.
- READY:
  - `s_ready=1` unless `iv_load=1`.
  - `iv_load` has priority: it reloads the IV, stays in READY, and accepts no block that cycle.
  - On `s_valid & s_ready`, latch `s_data`/`s_last`, drive `core_in=ctr`, and go to LAUNCH.
- LAUNCH: `core_load=1` for exactly one cycle, `lo <= lo+1`, then go to SETTLE.
- SETTLE: one cycle, which covers the core's registered `busy_ecb` rise. Then go to WAIT.
- WAIT: when `core_busy==0`, register `m_data <= data_reg ^ core_out` and `m_last <= last_reg`, then go to OUT.
- OUT:
  - `m_valid=1`.
  - `m_data`/`m_last` hold stable until `m_ready`.
  - On `m_ready`, go to READY.
- `iv_load` in LAUNCH, SETTLE, WAIT or OUT is ignored.
- `core_in` holds its value from acceptance until the next acceptance.

## Timing
- Reset (`aresetn=0` at a clock edge), from any state including mid-block:
  - The FSM goes to IDLE.
  - `s_ready`, `m_valid`, `m_last`, `core_load` and `ctr_exhausted` are all 0.
  - `m_data`, `core_in`, `iv_reg`, `lo` and the data buffer are all 0.
  - A block in flight is discarded. The core is not reset by this block.
  - An IV must be reloaded after reset.
- Accept at cycle A → `core_load` is high at A+1.
- The core result is captured the first cycle, from A+3 onward, with `core_busy==0`.
  - `m_valid` rises one cycle after that capture.
  - With the 33-cycle core, `m_valid` rises at A+36.
- Throughput: one block per (core latency + 4 + output stall) cycles.
- `s_ready` is 0 from A+1 until the cycle after the `m_valid & m_ready` handshake.
- If `m_ready` is already high when `m_valid` rises, OUT lasts exactly one cycle.

## Configuration
- `GOST_CTR_WRAP_GUARD_EN` defined:
  - When `lo` has wrapped to all-zero after an increment in LAUNCH, `ctr_exhausted` sets (sticky) and the FSM enters IDLE once the current OUT handshake completes.
  - `ctr_exhausted` clears on `iv_load` or reset.
- Not defined:
  - The `ctr_exhausted` port is absent.
  - The counter wraps silently and operation continues.

## Structure
- Package `gost34_13_2015_pkg` holds:
  - The FSM state enum `ctr_state_t` (IDLE, READY, LAUNCH, SETTLE, WAIT, OUT).
  - The constants `GOST_BLK_W=128` and `GOST_IV_W=64`.
- One sub-module, `gost34_13_2015_ctr_gen`:
  - Holds `iv_reg` and `lo`.
  - Has inputs load/inc and outputs `ctr` (and the wrap flag).
  - The FSM and datapath XOR stay in the top module.

## Test plan
All scenarios use a stub core with `out = in ^ 128'hA5A5...A5` and 33 cycles of busy.

1. Reset → all outputs 0. Without `iv_load`, pulsing `s_valid` gives `s_ready=0` and no `core_load`.
2. Single block:
   - Stimulus: IV=64'h0123456789ABCDEF, `s_data`=128'h0, `s_last`=1.
   - Required: `core_in`=128'h0123456789ABCDEF_0000000000000000; `m_data`=that value ^ A5…A5; `m_last`=1; `m_valid` at accept+36.
3. Three back-to-back blocks with `m_ready` stuck at 1 → `core_in` lower half 0, 1, 2. Each `m_data` is correct; `s_ready` is low while a block is in flight.
4. Backpressure: hold `m_ready=0` for 10 cycles in OUT → `m_data`/`m_valid` stable, `s_ready=0`, no extra `core_load`.
5. `iv_load` together with `s_valid` in READY → block not accepted that cycle, `lo`=0. Reset during WAIT → IDLE next cycle; the late `core_busy` fall is ignored.
6. With `GOST_CTR_WRAP_GUARD_EN`, preload `lo`=64'hFFFF_FFFF_FFFF_FFFF via a bench force and send 1 block → `ctr_exhausted`=1 after LAUNCH, FSM back in IDLE after OUT, and the flag clears on `iv_load`.
